// File: rtl/program_loader.sv
// Boot loader: streams a valid/ready image into instruction memory from address 0, holding the core in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word (sum of image words mod 2**DATA_W).
module program_loader #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_write_data,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, CHECK = 3'd2, RUN = 3'd3, ERROR = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd3} state_t;
`endif

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                load_done_q, load_done_d;
    logic [ADDR_W:0]     len_sel_s;
    logic                hs_s;
    logic                last_s;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                load_error_q, load_error_d;

    function automatic logic [DATA_W-1:0] checksum_add(input logic [DATA_W-1:0] acc,
                                                        input logic [DATA_W-1:0] word);
        return acc + word;
    endfunction
`endif

    // A zero or oversized length means a full-depth image
    assign len_sel_s = ((load_len == {(ADDR_W+1){1'b0}}) || (load_len > DEPTH_C)) ? DEPTH_C : load_len;
`ifdef LOADER_CHECKSUM_EN
    assign in_ready  = (state_q == LOAD) || (state_q == CHECK);
`else
    assign in_ready  = (state_q == LOAD);
`endif
    assign hs_s      = in_valid & in_ready;
    assign last_s    = (cnt_q == (len_q - ONE_C));

    // Next-state and next-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            LOAD: begin
                if (hs_s) begin
                    wr_en_d = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = in_data;
                    cnt_d   = cnt_q + ONE_C;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = checksum_add(sum_q, in_data);
                    state_d = last_s ? CHECK : LOAD;
`else
                    state_d = last_s ? RUN : LOAD;
`endif
                end else begin
                    state_d = LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (hs_s) begin
                    state_d = (in_data == sum_q) ? RUN : ERROR;
                end else begin
                    state_d = CHECK;
                end
            end
            IDLE, RUN, ERROR: begin
`else
            IDLE, RUN: begin
`endif
                if (load_start) begin
                    state_d = LOAD;
                    len_d   = len_sel_s;
                    cnt_d   = {(ADDR_W+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = {DATA_W{1'b0}};
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The core leaves reset only on the second RUN cycle, after the final write has landed
        cpu_reset_d = !((state_q == RUN) && (state_d == RUN));
        load_done_d = (state_d == RUN);
`ifdef LOADER_CHECKSUM_EN
        load_error_d = (state_d == ERROR);
`endif
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {(ADDR_W+1){1'b0}};
            len_q       <= {(ADDR_W+1){1'b0}};
            wr_en_q     <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= {DATA_W{1'b0}};
            load_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            load_error_q <= load_error_d;
`endif
        end
    end

    assign imem_wr_en      = wr_en_q;
    assign imem_addr       = addr_q;
    assign imem_write_data = wdata_q;
    assign cpu_reset       = cpu_reset_q;
    assign load_done       = load_done_q;
`ifdef LOADER_CHECKSUM_EN
    assign load_error      = load_error_q;
`else
    assign load_error      = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of loads, hand sequences for reset corners, randomized loads vs. an image model.
`timescale 1ns/1ps
module tb_program_loader;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_write_data;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;

    int n_checks = 0;
    int n_fail   = 0;
    logic data_word = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;
    wr_t wr_q[$];
    logic [DATA_W-1:0] words [DEPTH];

    typedef struct {
        logic [ADDR_W:0] len_in;
        int              gap;
        bit              mid_start;
        int              exp_len;
    } vec_t;
    vec_t vecs [6];

    program_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_wr_en(imem_wr_en), .imem_addr(imem_addr), .imem_write_data(imem_write_data),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int eff_len(input int l);
        return ((l == 0) || (l > DEPTH)) ? DEPTH : l;
    endfunction

    // Write monitor: a write must follow exactly the image-word handshakes of the previous cycle
    always @(posedge clk) begin
        logic exp_wr;
        exp_wr = in_valid && in_ready && data_word && !reset;
        #1;
        if (!reset) begin
            check("wr_en_vs_handshake", imem_wr_en, exp_wr);
            if (imem_wr_en) wr_q.push_back({imem_addr, imem_write_data});
        end
    end

    task automatic run_load(input logic [ADDR_W:0] len_in, input int gap, input bit mid_start,
                            input bit good_sum, input int eff, input string tag);
        int total, idx, cyc;
        bit ok, pulsed;
        logic [DATA_W-1:0] sum;
`ifdef LOADER_CHECKSUM_EN
        total = eff + 1;
        ok    = good_sum;
`else
        total = eff;
        ok    = 1'b1;
`endif
        wr_q.delete();
        @(negedge clk);
        load_start = 1'b1; load_len = len_in; in_valid = 1'b0; data_word = 1'b0;
        @(negedge clk);
        load_start = 1'b0; load_len = 5'd9;
        check($sformatf("%s_start_cpu_reset", tag), cpu_reset, 1'b1);
        check($sformatf("%s_start_done", tag), load_done, 1'b0);
        check($sformatf("%s_start_ready", tag), in_ready, 1'b1);
        check($sformatf("%s_start_error", tag), load_error, 1'b0);
        idx = 0; cyc = 0; sum = 12'h000; pulsed = 1'b0;
        while ((idx < total) && (cyc < 400)) begin
            bit v;
            case (gap)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (mid_start && (idx == 2) && !pulsed) begin
                load_start = 1'b1; load_len = 5'd2; pulsed = 1'b1;
            end else begin
                load_start = 1'b0;
            end
            in_valid  = v;
            data_word = (idx < eff);
            in_data   = (idx < eff) ? words[idx] : (good_sum ? sum : sum + 12'h001);
            if (v && in_ready) begin
                if (idx < eff) sum = sum + words[idx];
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_words_taken", tag), idx, total);
        // One cycle after the last handshake: final write visible, core still held
        load_start = 1'b0;
        in_valid = 1'b1; in_data = 12'hABC; data_word = 1'b1;
        check($sformatf("%s_done_first", tag), load_done, ok);
        check($sformatf("%s_cpu_reset_first", tag), cpu_reset, 1'b1);
        check($sformatf("%s_extra_ready", tag), in_ready, 1'b0);
        check($sformatf("%s_error_first", tag), load_error, !ok);
        @(negedge clk);
        check($sformatf("%s_cpu_reset_second", tag), cpu_reset, !ok);
        check($sformatf("%s_done_second", tag), load_done, ok);
        check($sformatf("%s_extra_ready2", tag), in_ready, 1'b0);
        check($sformatf("%s_error_second", tag), load_error, !ok);
        @(negedge clk);
        in_valid = 1'b0; data_word = 1'b0;
        @(negedge clk);
        check($sformatf("%s_write_count", tag), wr_q.size(), eff);
        for (int i = 0; (i < wr_q.size()) && (i < eff); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, i);
            check($sformatf("%s_data%0d", tag, i), wr_q[i].data, words[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{5'd0,  0, 1'b0, 16};
        vecs[1] = '{5'd3,  1, 1'b0, 3};
        vecs[2] = '{5'd2,  0, 1'b0, 2};
        vecs[3] = '{5'd16, 0, 1'b1, 16};
        vecs[4] = '{5'd17, 2, 1'b0, 16};
        vecs[5] = '{5'd31, 2, 1'b1, 16};

        reset = 1'b1; load_start = 1'b0; load_len = 5'd0; in_valid = 1'b0; in_data = 12'h000;
        #1;
        check("reset_cpu_reset", cpu_reset, 1'b1);
        check("reset_ready", in_ready, 1'b0);
        check("reset_wr_en", imem_wr_en, 1'b0);
        check("reset_addr", imem_addr, 4'h0);
        check("reset_wdata", imem_write_data, 12'h000);
        check("reset_done", load_done, 1'b0);
        check("reset_error", load_error, 1'b0);
        #22;
        reset = 1'b0;

        // Idle with no load_start: stream words offered but never consumed
        wr_q.delete();
        in_valid = 1'b1; in_data = 12'h5A5; data_word = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_cpu_reset", cpu_reset, 1'b1);
            check("idle_ready", in_ready, 1'b0);
            check("idle_done", load_done, 1'b0);
        end
        in_valid = 1'b0; data_word = 1'b0;
        check("idle_no_writes", wr_q.size(), 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < DEPTH; i++)
                words[i] = (v == 0) ? 12'(i + 1) : 12'($urandom);
            run_load(vecs[v].len_in, vecs[v].gap, vecs[v].mid_start, 1'b1, vecs[v].exp_len,
                     $sformatf("vec%0d", v));
        end

        // Async reset after 5 of 16 words, then a fresh load must restart at address 0
        wr_q.delete();
        for (int i = 0; i < DEPTH; i++) words[i] = 12'($urandom);
        @(negedge clk);
        load_start = 1'b1; load_len = 5'd0;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; data_word = 1'b1; in_data = words[i];
            @(negedge clk);
        end
        in_valid = 1'b0; data_word = 1'b0;
        check("midrst_writes_before", wr_q.size(), 5);
        reset = 1'b1;
        #1;
        check("midrst_wr_en", imem_wr_en, 1'b0);
        check("midrst_cpu_reset", cpu_reset, 1'b1);
        check("midrst_ready", in_ready, 1'b0);
        check("midrst_done", load_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_load(5'd4, 0, 1'b0, 1'b1, 4, "after_rst");

        // Randomized loads against the image model
        for (int r = 0; r < 8; r++) begin
            int l;
            l = $urandom_range(0, 31);
            for (int i = 0; i < DEPTH; i++) words[i] = 12'($urandom);
            run_load(5'(l), 2, 1'($urandom_range(0, 1)), 1'b1, eff_len(l), $sformatf("rnd%0d", r));
        end

`ifdef LOADER_CHECKSUM_EN
        words[0] = 12'h800; words[1] = 12'h801;
        run_load(5'd2, 0, 1'b0, 1'b1, 2, "csum_good");
        run_load(5'd2, 0, 1'b0, 1'b0, 2, "csum_bad");
        repeat (3) @(negedge clk);
        check("csum_error_held", load_error, 1'b1);
        check("csum_error_cpu_reset", cpu_reset, 1'b1);
        run_load(5'd2, 1, 1'b0, 1'b1, 2, "csum_recover");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
